uart_rx_edge_bit_sampler: RTL



---
 rtl/uart_rx_edge_bit_sampler_pkg.sv | 22 ++
 rtl/uart_rx_sync2.sv | 29 ++
 rtl/uart_rx_edge_bit_sampler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_edge_bit_sampler_pkg.sv
// Shared definitions for the UART RX edge/bit sampler: sampler state encoding,
// prescale floor, bit counter width and the stop-bit index helper.
package uart_rx_edge_bit_sampler_pkg;

  typedef enum logic [2:0] {
    SMP_WAIT = 3'd0,
    SMP_S1   = 3'd1,
    SMP_S2   = 3'd2,
    SMP_S3   = 3'd3,
    SMP_VOTE = 3'd4
  } smp_state_e;

  localparam int unsigned P_MIN     = 8;
  localparam int unsigned BIT_CNT_W = 4;

  // Index of the stop bit: start(0) + data bits + optional parity.
  function automatic logic [BIT_CNT_W-1:0] last_bit_index(input int unsigned data_w,
                                                          input logic        parity_en);
    last_bit_index = BIT_CNT_W'(data_w + 1) + {{(BIT_CNT_W-1){1'b0}}, parity_en};
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the serial line; both stages reset to the idle level (1).
module uart_rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX oversampling counters plus 3-sample majority-vote bit recovery.
// Define UART_RX_SYNC_EN to insert a 2-flop synchronizer on rx_in.
module uart_rx_edge_bit_sampler
  import uart_rx_edge_bit_sampler_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parity_en,
  input  logic                  counter_enable,
  input  logic                  sampler_enable,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  noise_flag
);

  localparam logic [PRESCALE_W-1:0] P_FLOOR = PRESCALE_W'(P_MIN);

  logic line;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (line)
  );
`else
  assign line = rx_in;
`endif

  logic [PRESCALE_W-1:0] p_q, p_d, p_req;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] edge_count_q, edge_count_d;
  logic [BIT_CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [BIT_CNT_W-1:0]  last_idx;
  logic                  edge_last;

  // Prescale is even-only with a floor; frozen while a frame is being counted.
  always_comb begin
    p_req = prescale & ~PRESCALE_W'(1);
    if (p_req < P_FLOOR) begin
      p_req = P_FLOOR;
    end
    p_d = counter_enable ? p_q : p_req;
  end

  assign half      = p_q >> 1;
  assign last_idx  = last_bit_index(DATA_W, parity_en);
  assign edge_last = (edge_count_q == (p_q - PRESCALE_W'(1)));

  always_comb begin
    edge_count_d = '0;
    bit_count_d  = '0;
    if (counter_enable) begin
      if (edge_last) begin
        edge_count_d = '0;
        bit_count_d  = (bit_count_q >= last_idx) ? '0 : bit_count_q + BIT_CNT_W'(1);
      end else begin
        edge_count_d = edge_count_q + PRESCALE_W'(1);
        bit_count_d  = bit_count_q;
      end
    end
  end

  smp_state_e state_q, state_d;
  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       sampled_bit_q, sampled_bit_d;
  logic       sample_valid_q, sample_valid_d;
  logic       noise_flag_q, noise_flag_d;
  logic       run;
  logic       vote_maj;
  logic       vote_noise;

  assign run        = counter_enable & sampler_enable;
  assign vote_maj   = (s1_q & s2_q) | (s1_q & line) | (s2_q & line);
  assign vote_noise = ~((s1_q == s2_q) && (s2_q == line));

  // The third sample is folded straight into the vote so the result registers
  // as the FSM enters VOTE, making the strobe coincide with edge_count = H+2.
  always_comb begin
    state_d        = state_q;
    s1_d           = s1_q;
    s2_d           = s2_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    noise_flag_d   = noise_flag_q;
    case (state_q)
      SMP_WAIT: begin
        if (run && (edge_count_q == (half - PRESCALE_W'(2)))) begin
          state_d = SMP_S1;
        end
      end
      SMP_S1: begin
        if (!run) begin
          state_d = SMP_WAIT;
        end else begin
          s1_d    = line;
          state_d = SMP_S2;
        end
      end
      SMP_S2: begin
        if (!run) begin
          state_d = SMP_WAIT;
        end else begin
          s2_d    = line;
          state_d = SMP_S3;
        end
      end
      SMP_S3: begin
        if (!run) begin
          state_d = SMP_WAIT;
        end else begin
          sampled_bit_d  = vote_maj;
          noise_flag_d   = vote_noise;
          sample_valid_d = 1'b1;
          state_d        = SMP_VOTE;
        end
      end
      SMP_VOTE: begin
        state_d = SMP_WAIT;
      end
      default: begin
        state_d = SMP_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q            <= P_FLOOR;
      edge_count_q   <= '0;
      bit_count_q    <= '0;
      state_q        <= SMP_WAIT;
      s1_q           <= 1'b1;
      s2_q           <= 1'b1;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      noise_flag_q   <= 1'b0;
    end else begin
      p_q            <= p_d;
      edge_count_q   <= edge_count_d;
      bit_count_q    <= bit_count_d;
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      noise_flag_q   <= noise_flag_d;
    end
  end

  assign edge_count   = edge_count_q;
  assign bit_count    = bit_count_q;
  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign noise_flag   = noise_flag_q;

endmodule
